clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Mode and adjust controller for the BCD digital clock datapath. Sequences time setting by freezing the seconds chain and driving the minute and hour adjust enables (`En`, `AM`, `AH`) in step with the 1 Hz tick. Holds and edits an alarm time, detects the alarm match and times the ringing output. Produces digit-blank and display-select controls for the display path. Sits between the debounced front-panel keys and the hour/minute/second counter chain.

## Interface
- `RING_SECONDS`, 60: number of `tick_1hz` pulses the alarm rings before self-stopping (1..255).
- `AL_H_INIT`, 8'h07: alarm hour after reset (BCD, 24 h).
- `AL_M_INIT`, 8'h00: alarm minute after reset (BCD).

Clock and reset: one clock, `CP`; reset `nCR` is asynchronous and active-low.

- `CP`  in  1  system clock; all state changes on rising edge.
- `nCR`  in  1  asynchronous active-low reset.
- `tick_1hz`  in  1  one-`CP`-cycle pulse per second, aligned with the counters' 1 Hz count edge.
- `key_mode`  in  1  debounced, `CP`-synchronous level; rising edge advances mode.
- `key_inc`  in  1  debounced level; rising edge or hold increments the selected field.
- `key_stop`  in  1  debounced level; rising edge silences ringing, otherwise toggles arm.
- `hour`, `minute`, `second`  in  8 each  current 24 h BCD time from the counters.
- `En`  out  1  seconds-chain count enable.
- `AM`  out  1  minute adjust enable.
- `AH`  out  1  hour adjust enable.
- `alarm_h`, `alarm_m`  out  8 each  alarm time, BCD.
- `alarm_arm`  out  1  alarm armed.
- `alarm_on`  out  1  alarm ringing.
- `disp_alarm`  out  1  display path shows `alarm_h`/`alarm_m` instead of `hour`/`minute`.
- `blank`  out  6  digit blank mask, ordered {hourH, hourL, minH, minL, secH, secL}; 1 blanks the digit.
- `mode`  out  3  state code.

## Operation
- States, encoded as `mode`: RUN=0, SET_H=1, SET_M=2, AL_H=3, AL_M=4.
- Each `key_mode` rising edge moves RUN→SET_H→SET_M→AL_H→AL_M→RUN.
- Edge detection: previous-value registers reset to 1, so a key already held at reset release gives no edge.
- `En` is 0 in SET_H and SET_M and 1 in all other states. It is decoded from the state register.
- Adjust for the live time (SET_H drives `AH`, SET_M drives `AM`):
  - A `key_inc` rising edge sets `inc_pend`.
  - On each `tick_1hz` cycle: `AH` <= (SET_H && (`inc_pend` || `key_inc`)); `AM` gets the same in SET_M; `inc_pend` <= 0.
  - `AH`/`AM` therefore span exactly one 1 Hz count edge per request. A held key auto-repeats at 1 Hz.
  - Leaving the state forces the relevant output to 0 on the next `CP` cycle, independent of tick.
- AL_H / AL_M: each `key_inc` rising edge increments `alarm_h` (23→00) or `alarm_m` (59→00) in BCD in the next cycle. No auto-repeat. `disp_alarm`=1 in these states.
- Blink: `blink_ph` toggles on every `tick_1hz`.
  - SET_H and AL_H: `blank[5:4]` = `blink_ph`.
  - SET_M and AL_M: `blank[3:2]` = `blink_ph`.
  - All other bits are 0.
- Alarm start: on a `tick_1hz` cycle with `alarm_arm`, state ∉ {SET_H, SET_M}, `hour`==`alarm_h`, `minute`==`alarm_m`, `second`==8'h00 and not ringing:
  - `alarm_on` <= 1;
  - ring counter <= `RING_SECONDS`.
- Ringing: the counter decrements per tick. `alarm_on` clears on the tick where it reaches 0.
- `key_stop` rising edge: if ringing, clear `alarm_on` and leave `alarm_arm` unchanged; else toggle `alarm_arm`.
- Simultaneous events:
  - `key_mode` and `key_inc` edges in the same cycle: mode wins, inc discarded.
  - `key_stop` edge on a match tick: no ring starts.
  - Match during ringing: ignored.

## Timing
- Reset values: `mode`=RUN, `En`=1, `AM`=`AH`=0, `alarm_h`=`AL_H_INIT`, `alarm_m`=`AL_M_INIT`, `alarm_arm`=0, `alarm_on`=0, `disp_alarm`=0, `blank`=0, `blink_ph`=0, `inc_pend`=0, ring counter=0.
- Key edge → state/`mode`/alarm-field change: 1 `CP` cycle.
- Key edge → `AH`/`AM` high: at the next `tick_1hz` cycle +1. Held high until the tick after that.
- Match tick → `alarm_on`=1: next `CP` cycle.
- `nCR` low mid-operation: all outputs to reset values immediately. A pending adjust is lost.

## Test plan
- Reset with `key_mode` held high, release → `mode`=0, `En`=1, no mode change until the key drops and rises again.
- RUN, 2 mode edges → `mode`=2, `En`=0. One inc edge → `AM`=1 for exactly one tick window, `AH`=0. Hold `key_inc` 3 ticks → `AM` high 3 consecutive windows.
- AL_H: 25 inc edges from 07 → `alarm_h`=8'h08. AL_M: 60 inc edges → `alarm_m` returns to 8'h00. `disp_alarm`=1, `blank`=6'b110000/6'b000000 alternating per tick in AL_H.
- Armed, alarm 07:00, inputs 07:00:00 on tick → `alarm_on`=1 next cycle. With `RING_SECONDS`=3 it clears after 3 ticks. The same match in SET_H → no ring.
- Ringing, `key_stop` edge → `alarm_on`=0, `alarm_arm` stays 1. Next `key_stop` edge → `alarm_arm`=0.
- `key_mode` and `key_inc` edges in the same cycle in SET_H → `mode`=2, `AH` never asserts. `nCR` low while `AH`=1 → `AH`=0 asynchronously.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
//   Mode and adjust controller for the BCD digital clock. Freezes the
//   seconds chain while the live time is being set, drives the minute/hour
//   adjust enables in step with the 1 Hz tick, holds and edits the alarm
//   time, detects the alarm match and times the ringing output, and drives
//   digit blanking / display selection for the display path.
//
// Ports
//   CP          in   system clock, rising edge
//   nCR         in   asynchronous active-low reset
//   tick_1hz    in   one-cycle pulse per second, aligned with the count edge
//   key_mode    in   debounced level, rising edge advances mode
//   key_inc     in   debounced level, rising edge / hold increments field
//   key_stop    in   debounced level, silences ringing or toggles arm
//   hour/minute/second in  current 24 h BCD time
//   En          out  seconds-chain count enable
//   AM / AH     out  minute / hour adjust enables
//   alarm_h/m   out  alarm time, BCD
//   alarm_arm   out  alarm armed
//   alarm_on    out  alarm ringing
//   disp_alarm  out  display shows the alarm time
//   blank       out  {hourH,hourL,minH,minL,secH,secL}, 1 blanks the digit
//   mode        out  state code
module clock_set_ctrl #(
  parameter int         RING_SECONDS = 60,
  parameter logic [7:0] AL_H_INIT    = 8'h07,
  parameter logic [7:0] AL_M_INIT    = 8'h00
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       tick_1hz,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_stop,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  output logic       En,
  output logic       AM,
  output logic       AH,
  output logic [7:0] alarm_h,
  output logic [7:0] alarm_m,
  output logic       alarm_arm,
  output logic       alarm_on,
  output logic       disp_alarm,
  output logic [5:0] blank,
  output logic [2:0] mode
);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    SET_H = 3'd1,
    SET_M = 3'd2,
    AL_H  = 3'd3,
    AL_M  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       mode_prev_q, mode_prev_d;
  logic       inc_prev_q, inc_prev_d;
  logic       stop_prev_q, stop_prev_d;
  logic       inc_pend_q, inc_pend_d;
  logic       ah_q, ah_d;
  logic       am_q, am_d;
  logic [7:0] alarm_h_q, alarm_h_d;
  logic [7:0] alarm_m_q, alarm_m_d;
  logic       arm_q, arm_d;
  logic       on_q, on_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic       blink_q, blink_d;

  logic mode_edge, inc_edge, stop_edge;
  logic in_set, in_al, match;

  // BCD increment with wrap from maxv back to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
    if (v == maxv)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Previous-value registers reset to 1 so a key held through reset
  // release does not register as an edge. A mode edge swallows any
  // simultaneous inc edge.
  assign mode_edge = key_mode & ~mode_prev_q;
  assign inc_edge  = key_inc  & ~inc_prev_q & ~mode_edge;
  assign stop_edge = key_stop & ~stop_prev_q;

  assign in_set = (state_q == SET_H) || (state_q == SET_M);
  assign in_al  = (state_q == AL_H)  || (state_q == AL_M);

  // A stop edge on the match tick suppresses the ring start.
  assign match = tick_1hz && arm_q && !in_set && !on_q && !stop_edge &&
                 (hour == alarm_h_q) && (minute == alarm_m_q) &&
                 (second == 8'h00);

  always_comb begin
    state_d     = state_q;
    mode_prev_d = key_mode;
    inc_prev_d  = key_inc;
    stop_prev_d = key_stop;
    inc_pend_d  = inc_pend_q;
    ah_d        = ah_q;
    am_d        = am_q;
    alarm_h_d   = alarm_h_q;
    alarm_m_d   = alarm_m_q;
    arm_d       = arm_q;
    on_d        = on_q;
    ring_cnt_d  = ring_cnt_q;
    blink_d     = blink_q;

    if (mode_edge) begin
      case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        SET_M:   state_d = AL_H;
        AL_H:    state_d = AL_M;
        default: state_d = RUN;
      endcase
    end

    // Adjust enables change only on a tick, so each request covers exactly
    // one count edge; the key level at the tick gives 1 Hz auto-repeat.
    // Leaving the state drops the enable and the pending request at once.
    if (mode_edge) begin
      inc_pend_d = 1'b0;
      ah_d       = 1'b0;
      am_d       = 1'b0;
    end else if (tick_1hz) begin
      inc_pend_d = 1'b0;
      ah_d       = (state_q == SET_H) && (inc_pend_q || key_inc);
      am_d       = (state_q == SET_M) && (inc_pend_q || key_inc);
    end else if (inc_edge && in_set) begin
      inc_pend_d = 1'b1;
    end

    if (inc_edge && state_q == AL_H)
      alarm_h_d = bcd_inc(alarm_h_q, 8'h23);
    if (inc_edge && state_q == AL_M)
      alarm_m_d = bcd_inc(alarm_m_q, 8'h59);

    if (tick_1hz)
      blink_d = ~blink_q;

    if (on_q) begin
      if (stop_edge) begin
        on_d       = 1'b0;
        ring_cnt_d = 8'd0;
      end else if (tick_1hz) begin
        if (ring_cnt_q <= 8'd1) begin
          on_d       = 1'b0;
          ring_cnt_d = 8'd0;
        end else begin
          ring_cnt_d = ring_cnt_q - 8'd1;
        end
      end
    end else begin
      if (stop_edge)
        arm_d = ~arm_q;
      if (match) begin
        on_d       = 1'b1;
        ring_cnt_d = 8'(RING_SECONDS);
      end
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_q     <= RUN;
      mode_prev_q <= 1'b1;
      inc_prev_q  <= 1'b1;
      stop_prev_q <= 1'b1;
      inc_pend_q  <= 1'b0;
      ah_q        <= 1'b0;
      am_q        <= 1'b0;
      alarm_h_q   <= AL_H_INIT;
      alarm_m_q   <= AL_M_INIT;
      arm_q       <= 1'b0;
      on_q        <= 1'b0;
      ring_cnt_q  <= 8'd0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= mode_prev_d;
      inc_prev_q  <= inc_prev_d;
      stop_prev_q <= stop_prev_d;
      inc_pend_q  <= inc_pend_d;
      ah_q        <= ah_d;
      am_q        <= am_d;
      alarm_h_q   <= alarm_h_d;
      alarm_m_q   <= alarm_m_d;
      arm_q       <= arm_d;
      on_q        <= on_d;
      ring_cnt_q  <= ring_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign En         = !in_set;
  assign AH         = ah_q;
  assign AM         = am_q;
  assign alarm_h    = alarm_h_q;
  assign alarm_m    = alarm_m_q;
  assign alarm_arm  = arm_q;
  assign alarm_on   = on_q;
  assign disp_alarm = in_al;
  assign mode       = state_q;

  always_comb begin
    blank = 6'b000000;
    if (state_q == SET_H || state_q == AL_H)
      blank[5:4] = {blink_q, blink_q};
    if (state_q == SET_M || state_q == AL_M)
      blank[3:2] = {blink_q, blink_q};
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl
//   Scoreboard bench for clock_set_ctrl: expectations are queued alongside
//   the stimulus and drained against the DUT outputs one step later.
module tb_clock_set_ctrl;

  localparam int RING = 3;

  localparam int S_MODE  = 0;
  localparam int S_EN    = 1;
  localparam int S_AM    = 2;
  localparam int S_AH    = 3;
  localparam int S_ALH   = 4;
  localparam int S_ALM   = 5;
  localparam int S_ARM   = 6;
  localparam int S_ON    = 7;
  localparam int S_DISP  = 8;
  localparam int S_BLANK = 9;

  logic       CP = 1'b0;
  logic       nCR = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       key_mode = 1'b1;
  logic       key_inc = 1'b0;
  logic       key_stop = 1'b0;
  logic [7:0] hour = 8'h00;
  logic [7:0] minute = 8'h00;
  logic [7:0] second = 8'h00;
  logic       En, AM, AH, alarm_arm, alarm_on, disp_alarm;
  logic [7:0] alarm_h, alarm_m;
  logic [5:0] blank;
  logic [2:0] mode;

  clock_set_ctrl #(
    .RING_SECONDS(RING),
    .AL_H_INIT(8'h07),
    .AL_M_INIT(8'h00)
  ) dut (
    .CP(CP), .nCR(nCR), .tick_1hz(tick_1hz),
    .key_mode(key_mode), .key_inc(key_inc), .key_stop(key_stop),
    .hour(hour), .minute(minute), .second(second),
    .En(En), .AM(AM), .AH(AH),
    .alarm_h(alarm_h), .alarm_m(alarm_m),
    .alarm_arm(alarm_arm), .alarm_on(alarm_on),
    .disp_alarm(disp_alarm), .blank(blank), .mode(mode)
  );

  always #5 CP = ~CP;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  logic exp_blink = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_MODE:  return 32'(mode);
      S_EN:    return 32'(En);
      S_AM:    return 32'(AM);
      S_AH:    return 32'(AH);
      S_ALH:   return 32'(alarm_h);
      S_ALM:   return 32'(alarm_m);
      S_ARM:   return 32'(alarm_arm);
      S_ON:    return 32'(alarm_on);
      S_DISP:  return 32'(disp_alarm);
      S_BLANK: return 32'(blank);
      default: return 32'hDEAD;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic expect_v(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, actual(e.sel), e.exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CP);
      #1;
    end
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
    exp_blink = ~exp_blink;
  endtask

  task automatic press_mode();
    key_mode = 1'b1;
    cyc(1);
    key_mode = 1'b0;
    cyc(1);
  endtask

  task automatic press_inc();
    key_inc = 1'b1;
    cyc(1);
    key_inc = 1'b0;
    cyc(1);
  endtask

  task automatic press_stop();
    key_stop = 1'b1;
    cyc(1);
    key_stop = 1'b0;
    cyc(1);
  endtask

  function automatic logic [31:0] blank_hr();
    return 32'({exp_blink, exp_blink, 4'b0000});
  endfunction

  function automatic logic [31:0] blank_min();
    return 32'({2'b00, exp_blink, exp_blink, 2'b00});
  endfunction

  initial begin
    // Reset held with key_mode high
    #12;
    expect_v("rst_mode", S_MODE, 0);
    expect_v("rst_en", S_EN, 1);
    expect_v("rst_am", S_AM, 0);
    expect_v("rst_ah", S_AH, 0);
    expect_v("rst_alh", S_ALH, 32'h07);
    expect_v("rst_alm", S_ALM, 32'h00);
    expect_v("rst_arm", S_ARM, 0);
    expect_v("rst_on", S_ON, 0);
    expect_v("rst_disp", S_DISP, 0);
    expect_v("rst_blank", S_BLANK, 0);
    drain();
    @(posedge CP);
    #1;
    nCR = 1'b1;
    cyc(3);
    expect_v("held_key_no_edge", S_MODE, 0);
    expect_v("held_key_en", S_EN, 1);
    drain();
    key_mode = 1'b0;
    cyc(1);

    // Into SET_H, then SET_M
    press_mode();
    expect_v("set_h_mode", S_MODE, 1);
    expect_v("set_h_en", S_EN, 0);
    drain();
    press_mode();
    expect_v("set_m_mode", S_MODE, 2);
    expect_v("set_m_en", S_EN, 0);
    expect_v("set_m_blank", S_BLANK, blank_min());
    drain();

    // Single inc request spans one tick window
    press_inc();
    expect_v("am_before_tick", S_AM, 0);
    drain();
    do_tick();
    expect_v("am_window", S_AM, 1);
    expect_v("ah_idle", S_AH, 0);
    drain();
    cyc(3);
    expect_v("am_held", S_AM, 1);
    drain();
    do_tick();
    expect_v("am_end", S_AM, 0);
    drain();

    // Held key repeats at 1 Hz
    key_inc = 1'b1;
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      expect_v($sformatf("am_repeat%0d", i), S_AM, 1);
      expect_v($sformatf("blank_set_m%0d", i), S_BLANK, blank_min());
      drain();
      cyc(2);
    end
    key_inc = 1'b0;
    cyc(1);
    do_tick();
    expect_v("am_repeat_end", S_AM, 0);
    drain();

    // AL_H: 25 increments from 07
    press_mode();
    expect_v("al_h_mode", S_MODE, 3);
    expect_v("al_h_disp", S_DISP, 1);
    expect_v("al_h_en", S_EN, 1);
    expect_v("al_h_am", S_AM, 0);
    drain();
    for (int i = 0; i < 25; i++) press_inc();
    expect_v("alh_wrap", S_ALH, 32'(to_bcd((7 + 25) % 24)));
    drain();
    do_tick();
    expect_v("al_h_blank_a", S_BLANK, blank_hr());
    drain();
    do_tick();
    expect_v("al_h_blank_b", S_BLANK, blank_hr());
    drain();

    // AL_M: 60 increments wrap back to 00
    press_mode();
    expect_v("al_m_mode", S_MODE, 4);
    expect_v("al_m_blank", S_BLANK, blank_min());
    drain();
    for (int i = 0; i < 9; i++) press_inc();
    expect_v("alm_09", S_ALM, 32'(to_bcd(9)));
    drain();
    press_inc();
    expect_v("alm_10", S_ALM, 32'(to_bcd(10)));
    drain();
    for (int i = 0; i < 50; i++) press_inc();
    expect_v("alm_wrap", S_ALM, 32'h00);
    expect_v("alh_kept", S_ALH, 32'h08);
    drain();

    // Back to RUN, arm, ring for RING ticks
    press_mode();
    expect_v("run_mode", S_MODE, 0);
    expect_v("run_disp", S_DISP, 0);
    expect_v("run_blank", S_BLANK, 0);
    drain();
    press_stop();
    expect_v("arm_on", S_ARM, 1);
    drain();
    hour = 8'h08;
    minute = 8'h00;
    second = 8'h00;
    do_tick();
    expect_v("ring_start", S_ON, 1);
    drain();
    second = 8'h01;
    for (int i = 1; i < RING; i++) begin
      do_tick();
      expect_v($sformatf("ringing%0d", i), S_ON, 1);
      drain();
    end
    do_tick();
    expect_v("ring_self_stop", S_ON, 0);
    expect_v("ring_arm_kept", S_ARM, 1);
    drain();

    // Match while in SET_H does not ring
    press_mode();
    second = 8'h00;
    do_tick();
    expect_v("set_h_no_ring", S_ON, 0);
    expect_v("set_h_no_ah", S_AH, 0);
    drain();
    for (int i = 0; i < 4; i++) press_mode();
    expect_v("run_again", S_MODE, 0);
    drain();

    // Stop while ringing, then disarm
    do_tick();
    expect_v("ring_start2", S_ON, 1);
    drain();
    second = 8'h01;
    press_stop();
    expect_v("stop_silences", S_ON, 0);
    expect_v("stop_arm_kept", S_ARM, 1);
    drain();
    press_stop();
    expect_v("stop_disarm", S_ARM, 0);
    drain();

    // Stop edge on the match tick: arm toggles, no ring
    press_stop();
    expect_v("rearm", S_ARM, 1);
    drain();
    second = 8'h00;
    key_stop = 1'b1;
    tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
    key_stop = 1'b0;
    exp_blink = ~exp_blink;
    cyc(1);
    expect_v("stop_on_match_no_ring", S_ON, 0);
    expect_v("stop_on_match_arm", S_ARM, 0);
    drain();
    second = 8'h01;

    // Mode and inc edges together in SET_H
    press_mode();
    expect_v("set_h_again", S_MODE, 1);
    drain();
    key_mode = 1'b1;
    key_inc = 1'b1;
    cyc(1);
    expect_v("mode_wins", S_MODE, 2);
    drain();
    key_mode = 1'b0;
    key_inc = 1'b0;
    cyc(1);
    do_tick();
    expect_v("inc_discarded_ah", S_AH, 0);
    expect_v("inc_discarded_am", S_AM, 0);
    drain();

    // Asynchronous reset while AH is high
    for (int i = 0; i < 4; i++) press_mode();
    expect_v("set_h_third", S_MODE, 1);
    drain();
    press_inc();
    do_tick();
    expect_v("ah_window", S_AH, 1);
    expect_v("ah_blank", S_BLANK, blank_hr());
    drain();
    #2;
    nCR = 1'b0;
    #1;
    exp_blink = 1'b0;
    expect_v("async_ah", S_AH, 0);
    expect_v("async_mode", S_MODE, 0);
    expect_v("async_en", S_EN, 1);
    expect_v("async_alh", S_ALH, 32'h07);
    expect_v("async_blank", S_BLANK, 0);
    drain();
    @(posedge CP);
    #1;
    nCR = 1'b1;
    cyc(1);
    do_tick();
    expect_v("pending_lost", S_AH, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
